// File: rtl/acq_seq_pkg.sv
// Shared types and helpers for the waveform acquisition sequencer.
// The readout length covers every data record plus the trailer record and a settling margin.
package acq_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    CAPTURE,
    READOUT,
    HOLDOFF
  } acq_state_t;

  localparam int BITS_PER_RECORD = 36;

  function automatic int readout_len(input int num_samples, input int bits_per_record,
                                     input int margin);
    return (num_samples + 1) * bits_per_record + margin;
  endfunction

endpackage

// File: rtl/trigger_edge_detect.sv
// Rising edge of the external trigger level OR'd with the software trigger pulse.
// Zero-cycle output; the previous trigger level is held in a flop.
module trigger_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic trigger,
  input  logic sw_trigger,
  output logic trig
);

  logic trigger_q;

  always_ff @(posedge clk) begin
    if (reset) trigger_q <= 1'b0;
    else       trigger_q <= trigger;
  end

  assign trig = (trigger & ~trigger_q) | sw_trigger;

endmodule

// File: rtl/acquisition_sequencer.sv
// Arms on trigger, captures NUM_SAMPLES ADC words, then holds acquire low for one full serializer frame.
// Buffer writes are registered (1-cycle latency); no backpressure, adc_valid strobes are taken as they come.
module acquisition_sequencer #(
  parameter int NUM_SAMPLES     = 2000,
  parameter int SAMPLE_W        = 14,
  parameter int BITS_PER_RECORD = acq_seq_pkg::BITS_PER_RECORD,
  parameter int READOUT_MARGIN  = 16,
  parameter int HOLDOFF_CYCLES  = 4,
  localparam int AW             = $clog2(NUM_SAMPLES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                trigger,
  input  logic                sw_trigger,
  input  logic                adc_valid,
  input  logic [SAMPLE_W-1:0] adc_data,
  output logic                wr_en,
  output logic [AW-1:0]       wr_addr,
  output logic [SAMPLE_W-1:0] wr_data,
  output logic                acquire,
  output logic [15:0]         waveNumber,
  output logic                busy,
  output logic [15:0]         missed_triggers
);

  import acq_seq_pkg::*;

  localparam int READOUT_LEN = readout_len(NUM_SAMPLES, BITS_PER_RECORD, READOUT_MARGIN);
  localparam int TW          = $clog2(READOUT_LEN + 1);
  localparam int CW          = $clog2(NUM_SAMPLES + 1);

  localparam logic [CW-1:0] CNT_FULL = CW'(NUM_SAMPLES);
  localparam logic [TW-1:0] RO_LAST  = TW'(READOUT_LEN - 1);
  localparam logic [TW-1:0] HO_LAST  = TW'(HOLDOFF_CYCLES - 1);

  acq_state_t     state, state_nxt;
  logic           trig;
  logic [CW-1:0]  sample_cnt;
  logic [TW-1:0]  timer;
  logic           wr_fire;
  logic           wave_inc;
  logic           miss_inc;

  trigger_edge_detect u_trig (
    .clk        (clk),
    .reset      (reset),
    .trigger    (trigger),
    .sw_trigger (sw_trigger),
    .trig       (trig)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Disable wins over trigger; readout always runs to completion so the frame is never cut short.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = ARMED;
      ARMED: begin
        if (!enable)   state_nxt = IDLE;
        else if (trig) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (!enable)                   state_nxt = IDLE;
        else if (sample_cnt == CNT_FULL) state_nxt = READOUT;
      end
      READOUT: if (timer == RO_LAST) state_nxt = HOLDOFF;
      HOLDOFF: if (timer == HO_LAST) state_nxt = enable ? ARMED : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    acquire  = (state != READOUT);
    busy     = (state == CAPTURE) || (state == READOUT);
    wr_fire  = (state == CAPTURE) && adc_valid && (sample_cnt != CNT_FULL);
    wave_inc = (state == READOUT) && (timer == RO_LAST);
    miss_inc = trig && (missed_triggers != 16'hFFFF) &&
               ((state == CAPTURE) || (state == READOUT) || (state == HOLDOFF));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en           <= 1'b0;
      wr_addr         <= '0;
      wr_data         <= '0;
      sample_cnt      <= '0;
      timer           <= '0;
      waveNumber      <= '0;
      missed_triggers <= '0;
    end else begin
      wr_en <= wr_fire;
      if (wr_fire) begin
        wr_addr <= sample_cnt[AW-1:0];
        wr_data <= adc_data;
      end

      if (state != CAPTURE) sample_cnt <= '0;
      else if (wr_fire)     sample_cnt <= sample_cnt + CW'(1);

      // Timer restarts on every state change and only runs where it is compared.
      if ((state_nxt != state) || ((state != READOUT) && (state != HOLDOFF))) timer <= '0;
      else                                                                  timer <= timer + TW'(1);

      waveNumber <= waveNumber + 16'(wave_inc);
      if (miss_inc) missed_triggers <= missed_triggers + 16'd1;
    end
  end

endmodule

// File: tb/tb_acquisition_sequencer.sv
// Randomized scoreboard bench: stimulus pushes expected writes/readouts, a negedge monitor pops and compares.
module tb_acquisition_sequencer;

  localparam int NS     = 4;
  localparam int SW     = 14;
  localparam int BPR    = 36;
  localparam int MARGIN = 2;
  localparam int HOLD   = 3;
  localparam int RLEN   = (NS + 1) * BPR + MARGIN;

  logic          clk = 1'b0;
  logic          reset, enable, trigger, sw_trigger, adc_valid;
  logic [SW-1:0] adc_data;
  logic          wr_en;
  logic [1:0]    wr_addr;
  logic [SW-1:0] wr_data;
  logic          acquire;
  logic [15:0]   waveNumber;
  logic          busy;
  logic [15:0]   missed_triggers;

  always #5 clk = ~clk;

  acquisition_sequencer #(
    .NUM_SAMPLES    (NS),
    .SAMPLE_W       (SW),
    .BITS_PER_RECORD(BPR),
    .READOUT_MARGIN (MARGIN),
    .HOLDOFF_CYCLES (HOLD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .trigger        (trigger),
    .sw_trigger     (sw_trigger),
    .adc_valid      (adc_valid),
    .adc_data       (adc_data),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .acquire        (acquire),
    .waveNumber     (waveNumber),
    .busy           (busy),
    .missed_triggers(missed_triggers)
  );

  typedef struct { int addr; int data; } wr_exp_t;
  typedef struct { int len; int wave; } ro_exp_t;

  wr_exp_t wq[$];
  ro_exp_t rq[$];

  int n_checks = 0;
  int n_fail = 0;
  int readouts_seen = 0;
  int exp_wave = 0;
  int exp_missed = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write and every completed acquire-low window is matched against the scoreboard.
  int cyc = 0;
  int low_run = 0;
  int last_wr_cyc = -100;
  bit prev_acq = 1'b1;

  always @(negedge clk) begin
    wr_exp_t we;
    ro_exp_t re;
    cyc++;
    if (reset) begin
      low_run  = 0;
      prev_acq = 1'b1;
    end else begin
      if (wr_en) begin
        if (wq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0d data %0d, expected no write", wr_addr, wr_data);
        end else begin
          we = wq.pop_front();
          check("wr_addr", int'(wr_addr), we.addr);
          check("wr_data", int'(wr_data), we.data);
        end
        last_wr_cyc = cyc;
      end
      if (!acquire) begin
        if (prev_acq) check("acquire_fall_delay", cyc - last_wr_cyc, 1);
        low_run++;
      end else if (low_run > 0) begin
        if (rq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_readout: got %0d low cycles, expected none", low_run);
        end else begin
          re = rq.pop_front();
          check("readout_len", low_run, re.len);
          check("wave_after_readout", int'(waveNumber), re.wave);
        end
        readouts_seen++;
        low_run = 0;
      end
      prev_acq = acquire;
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_acquire"}, int'(acquire), 1);
    check({tag, "_wr_en"}, int'(wr_en), 0);
    check({tag, "_wr_addr"}, int'(wr_addr), 0);
    check({tag, "_wr_data"}, int'(wr_data), 0);
    check({tag, "_waveNumber"}, int'(waveNumber), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_missed"}, int'(missed_triggers), 0);
  endtask

  // Starts from ARMED: one trigger cycle (its sample must be dropped), then nsamp strobes spaced by gap.
  task automatic capture(input int gap, input bit use_sw, input bit hold_trig,
                         input bit seq, input int nsamp);
    wr_exp_t e;
    if (use_sw) sw_trigger = 1'b1;
    else        trigger    = 1'b1;
    adc_valid = 1'b1;
    adc_data  = SW'($urandom);
    step();
    sw_trigger = 1'b0;
    if (!use_sw && !hold_trig) trigger = 1'b0;
    for (int k = 0; k < nsamp; k++) begin
      adc_valid = 1'b1;
      adc_data  = seq ? SW'(k + 1) : SW'($urandom);
      e.addr = k;
      e.data = int'(adc_data);
      wq.push_back(e);
      step();
      for (int g = 1; g < gap; g++) begin
        adc_valid = 1'b0;
        step();
      end
    end
    adc_valid = 1'b0;
    if (nsamp == NS) begin
      ro_exp_t r;
      exp_wave = (exp_wave + 1) & 16'hFFFF;
      r.len  = RLEN;
      r.wave = exp_wave;
      rq.push_back(r);
    end
  endtask

  task automatic wait_record(input bit sw_in_holdoff);
    int  target = readouts_seen + 1;
    bit  done   = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      adc_valid = 1'($urandom);
      adc_data  = SW'($urandom);
      step();
      if (readouts_seen >= target) done = 1'b1;
    end
    adc_valid = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL record_timeout: got %0d readouts, expected %0d", readouts_seen, target);
    end
    if (sw_in_holdoff) begin
      sw_trigger = 1'b1;
      step();
      sw_trigger = 1'b0;
      exp_missed++;
    end
    repeat (5) step();
  endtask

  task automatic idle_random(input int n);
    for (int i = 0; i < n; i++) begin
      adc_valid = 1'($urandom);
      adc_data  = SW'($urandom);
      step();
    end
    adc_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; trigger = 1'b0; sw_trigger = 1'b0;
    adc_valid = 1'b0; adc_data = '0;
    repeat (3) step();
    check_reset_values("reset");
    reset = 1'b0;
    enable = 1'b1;
    repeat (2) step();
    check("armed_acquire", int'(acquire), 1);
    check("armed_busy", int'(busy), 0);

    // Back-to-back samples with data 1..4.
    capture(1, 1'b0, 1'b0, 1'b1, NS);
    check("capture_busy", int'(busy), 1);
    wait_record(1'b0);
    check("t1_wave", int'(waveNumber), 1);

    // Sparse strobes; a software trigger lands in HOLDOFF and is counted as missed.
    capture(3, 1'b0, 1'b0, 1'b0, NS);
    wait_record(1'b1);
    check("t2_missed", int'(missed_triggers), exp_missed);

    // Three edges during READOUT are counted and never start a capture.
    capture(1, 1'b0, 1'b0, 1'b0, NS);
    repeat (10) step();
    for (int p = 0; p < 3; p++) begin
      trigger = 1'b1; step();
      trigger = 1'b0; step();
    end
    exp_missed += 3;
    check("t3_missed_in_readout", int'(missed_triggers), exp_missed);
    wait_record(1'b0);
    idle_random(20);
    check("t3_no_recapture", int'(busy), 0);

    // Abort mid-capture, then disable during readout.
    capture(1, 1'b0, 1'b0, 1'b0, 2);
    enable = 1'b0;
    repeat (2) step();
    check("t4_abort_busy", int'(busy), 0);
    check("t4_abort_acquire", int'(acquire), 1);
    check("t4_abort_wave", int'(waveNumber), exp_wave);
    idle_random(5);
    enable = 1'b1;
    repeat (2) step();
    capture(1, 1'b0, 1'b0, 1'b0, NS);
    repeat (5) step();
    enable = 1'b0;
    wait_record(1'b0);
    check("t4_idle_busy", int'(busy), 0);
    trigger = 1'b1; step();
    trigger = 1'b0;
    idle_random(5);
    check("t4_idle_trig_ignored", int'(missed_triggers), exp_missed);
    check("t4_idle_no_capture", int'(busy), 0);
    enable = 1'b1;
    repeat (2) step();

    // Record counter wrap from FFFF.
    force dut.waveNumber = 16'hFFFF;
    repeat (2) step();
    release dut.waveNumber;
    exp_wave = 16'hFFFF;
    step();
    check("t5_preload", int'(waveNumber), exp_wave);
    capture(1, 1'b0, 1'b0, 1'b0, NS);
    wait_record(1'b0);
    check("t5_wrap", int'(waveNumber), 0);

    // Reset in the middle of READOUT.
    capture(1, 1'b0, 1'b0, 1'b0, NS);
    repeat (20) step();
    check("t5_in_readout", int'(acquire), 0);
    rq.delete();
    reset = 1'b1;
    repeat (2) step();
    check_reset_values("midreset");
    exp_wave = 0;
    exp_missed = 0;
    reset = 1'b0;
    repeat (2) step();

    // Held trigger level yields exactly one capture; software pulse still arms.
    capture(1, 1'b0, 1'b1, 1'b0, NS);
    wait_record(1'b0);
    idle_random(20);
    check("t6_single_capture", int'(busy), 0);
    check("t6_missed", int'(missed_triggers), exp_missed);
    capture(1, 1'b1, 1'b1, 1'b0, NS);
    wait_record(1'b0);
    check("t6_sw_wave", int'(waveNumber), exp_wave);
    trigger = 1'b0;
    repeat (3) step();

    check("write_queue_drained", wq.size(), 0);
    check("readout_queue_drained", rq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
